seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed N-digit seven-segment display driver for the MicroBlaze MCS system. It replaces the fixed single-anode hookup, where GPO drove segments directly and one anode was tied on. Software writes hex nibbles, decimal points and blanking mask through a GPO strobe. The block double-buffers them, scans the digits with inter-digit dead time, and commits new data only at frame boundaries so the display never tears.

## Interface
- DIGITS, 4: number of digits/anodes (1..8).
- CLK_HZ, 50_000_000: CLK frequency in Hz.
- SCAN_HZ, 1000: per-digit dwell rate in Hz; DIV = CLK_HZ/SCAN_HZ cycles per digit slot.
- DEAD_CYC, 64: cycles per slot with all anodes off (ghosting guard); requires 1 <= DEAD_CYC < DIV.
- CLK  in  1  system clock (50 MHz). Single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- WE  in  1  load strobe; samples DIN/DP/BLANK into shadow.
- DIN  in  4*DIGITS  hex nibbles; [3:0] = digit 0 (rightmost, nAN[0]).
- DP  in  DIGITS  decimal point per digit, 1 = lit.
- BLANK  in  DIGITS  1 = digit forced dark.
- nSEG  out  8  active-low segments, [7]=DP, [6:0]=g..a.
- nAN  out  DIGITS  active-low anodes.
- FRAME  out  1  one-cycle pulse at start of each full scan.

## Operation
- Registers: slot counter cnt (0..DIV-1), digit index idx (0..DIGITS-1), shadow {DIN,DP,BLANK}, pending flag, display {DIN,DP,BLANK}, state.
- States: DEAD (cnt < DEAD_CYC) drives nAN all 1 and nSEG 8'hFF. SHOW (cnt >= DEAD_CYC) drives nAN[idx]=0 and nSEG = decode(display nibble idx, DP[idx]).
- Decode, active low gfedcba: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. nSEG[7] = ~DP.
- BLANK[idx]=1 in SHOW: nAN stays all 1 and nSEG = 8'hFF.
- cnt==DIV-1: cnt<=0 and idx<=idx+1. idx wraps DIGITS-1 -> 0. On the wrap, FRAME<=1 for one cycle; if pending, display<=shadow and pending<=0.
- WE=1: shadow<=inputs, pending<=1. WE held multiple cycles: last sample wins.
- WE in the same cycle as a wrap: the commit uses the old shadow; the new data is captured into shadow and pending stays 1, so it commits at the next frame.
- At most one anode is ever low. nAN and nSEG are both registered and change on the same edge.

## Timing
- Reset values: nSEG=8'hFF, nAN=all 1, FRAME=0, cnt=0, idx=0, state DEAD, shadow=0, display=0, pending=0.
- Reset is asynchronous on assert, including mid-scan. Outputs go dark immediately.
- Output latency: 1 cycle after cnt/idx.
- After RST deasserts, first anode low (nAN[0]) appears at cycle DEAD_CYC+1.
- Frame period: DIGITS*DIV cycles.
- Write-to-visible latency: until the next FRAME, at most DIGITS*DIV+1 cycles.
- cnt width: clog2(DIV). No other arithmetic beyond wrap-compares.

## Configuration
- SEG7_LEADZERO_EN defined: leading-zero suppression. Digit k>0 is treated as BLANK when its nibble and all higher nibbles are 0 and none of their DP bits are set. Digit 0 is never suppressed.
- SEG7_LEADZERO_EN undefined: every non-BLANK digit shows its nibble, zeros included.

## Test plan
Bench parameters: DIGITS=4, CLK_HZ=1000, SCAN_HZ=100 (DIV=10), DEAD_CYC=2.
- Reset and idle: assert RST, then release. nSEG=FF, nAN=F during reset. Cycles 1-2 show nAN=F. Cycle 3 shows nAN=E, nSEG=C0 (display 0). FRAME period is 40 cycles.
- Write DIN=16'h1234, DP=4'b0001, WE 1 cycle. After the next FRAME: nAN=E with nSEG=19, nAN=D with nSEG=B0, nAN=B with nSEG=A4, nAN=7 with nSEG=F9, each for 8 cycles, separated by 2-cycle all-dark gaps.
- Tearing: with 1234 displayed, write 16'h00FF mid-frame. Remaining digits of the current frame still show 1234. New data appears only after FRAME.
- Collision: WE with 16'hABCD on the wrap cycle while pending holds 16'h5555. The frame shows 5555. The following frame shows ABCD.
- BLANK=4'b0100 with 1234: nAN never equals B. All other digits unchanged.
- Mid-scan RST with 16'h0008 loaded: outputs dark immediately and display clears to 0. Reloading 0008 with SEG7_LEADZERO_EN defined gives only nAN=E active (nSEG=80). Without the macro, all digits are active and digits 1-3 show C0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Software-side load port and display-side outputs of the seven-segment scanner.
// The master modport is the writer/observer; the slave modport is the scanner itself.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  we;
    logic [4*DIGITS-1:0]   din;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [7:0]            n_seg;
    logic [DIGITS-1:0]     n_an;
    logic                  frame;

    modport master (output we, din, dp, blank, input n_seg, n_an, frame);
    modport slave  (input we, din, dp, blank, output n_seg, n_an, frame);
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit seven-segment driver with dead-time and frame-aligned commit.
// Optional leading-zero suppression is enabled by defining SEG7_LEADZERO_EN.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int DEAD_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    seg7_scan_if.slave    bus
);
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {DEAD, SHOW} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [4*DIGITS-1:0]   shadow_din_reg, disp_din_reg;
    logic [DIGITS-1:0]     shadow_dp_reg, disp_dp_reg;
    logic [DIGITS-1:0]     shadow_blank_reg, disp_blank_reg;
    logic                  pending_reg, pending_next;
    logic                  commit;
    logic [7:0]            n_seg_reg, n_seg_next;
    logic [DIGITS-1:0]     n_an_reg, n_an_next;
    logic                  frame_reg, frame_next;
    logic [DIGITS-1:0]     suppress;
    logic                  slot_end, wrap;
    logic [3:0]            nibble;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    // A digit is suppressed when it and every higher digit is zero with no DP lit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sup
`ifdef SEG7_LEADZERO_EN
            if (gi == 0) begin : g_first
                assign suppress[gi] = 1'b0;
            end else begin : g_rest
                assign suppress[gi] = ~(|disp_din_reg[4*DIGITS-1:4*gi]) &
                                      ~(|disp_dp_reg[DIGITS-1:gi]);
            end
`else
            assign suppress[gi] = 1'b0;
`endif
        end
    endgenerate

    assign nibble = disp_din_reg[{idx_reg, 2'b00} +: 4];

    always_comb begin
        slot_end     = (cnt_reg == CNT_W'(DIV - 1));
        wrap         = slot_end && (idx_reg == IDX_W'(DIGITS - 1));
        cnt_next     = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next     = idx_reg;
        if (slot_end)
            idx_next = wrap ? '0 : idx_reg + 1'b1;
        state_next   = (cnt_next >= CNT_W'(DEAD_CYC)) ? SHOW : DEAD;
        frame_next   = wrap;
        commit       = wrap && pending_reg;
        // A write landing on the wrap cycle keeps pending set for the next frame.
        pending_next = pending_reg;
        if (commit)
            pending_next = 1'b0;
        if (bus.we)
            pending_next = 1'b1;
        n_an_next    = '1;
        n_seg_next   = 8'hFF;
        if (state_reg == SHOW && !disp_blank_reg[idx_reg] && !suppress[idx_reg]) begin
            n_an_next  = ~(DIGITS'(1) << idx_reg);
            n_seg_next = {~disp_dp_reg[idx_reg], decode(nibble)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= DEAD;
            cnt_reg          <= '0;
            idx_reg          <= '0;
            shadow_din_reg   <= '0;
            shadow_dp_reg    <= '0;
            shadow_blank_reg <= '0;
            disp_din_reg     <= '0;
            disp_dp_reg      <= '0;
            disp_blank_reg   <= '0;
            pending_reg      <= 1'b0;
            n_seg_reg        <= 8'hFF;
            n_an_reg         <= '1;
            frame_reg        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
            n_seg_reg   <= n_seg_next;
            n_an_reg    <= n_an_next;
            frame_reg   <= frame_next;
            if (bus.we) begin
                shadow_din_reg   <= bus.din;
                shadow_dp_reg    <= bus.dp;
                shadow_blank_reg <= bus.blank;
            end
            if (commit) begin
                disp_din_reg   <= shadow_din_reg;
                disp_dp_reg    <= shadow_dp_reg;
                disp_blank_reg <= shadow_blank_reg;
            end
        end
    end

    assign bus.n_seg = n_seg_reg;
    assign bus.n_an  = n_an_reg;
    assign bus.frame = frame_reg;
endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: 4 digits, 10-cycle slots, 2 dead cycles.
module tb_seg7_scan;
    localparam int FRAME_LEN = 40;
    localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [12:0] sb [$];

    seg7_scan_if #(.DIGITS(4)) bus ();
    seg7_scan #(.DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYC(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected {frame, n_an, n_seg} for position j (0..39) of a frame.
    function automatic logic [12:0] exp_val(int j, logic [15:0] din, logic [3:0] dp, logic [3:0] blank);
        int d = j / 10;
        int c = j % 10;
        logic sup = 1'b0;
        logic [3:0] nib = din[d*4 +: 4];
        logic [3:0] an = 4'hF;
        logic [7:0] seg = 8'hFF;
`ifdef SEG7_LEADZERO_EN
        sup = (d > 0);
        for (int k = d; k < 4; k++)
            if (din[k*4 +: 4] != 4'h0 || dp[k]) sup = 1'b0;
`endif
        if (c >= 2 && !blank[d] && !sup) begin
            an  = ~(4'b0001 << d);
            seg = {~dp[d], SEG_TBL[nib]};
        end
        return {(j == FRAME_LEN - 1), an, seg};
    endfunction

    function automatic void push_frame(logic [15:0] din, logic [3:0] dp, logic [3:0] blank);
        for (int j = 0; j < FRAME_LEN; j++) sb.push_back(exp_val(j, din, dp, blank));
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (bus.frame === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic write(logic [15:0] din, logic [3:0] dp, logic [3:0] blank);
        bus.din = din; bus.dp = dp; bus.blank = blank; bus.we = 1'b1;
        step();
        bus.we = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        bus.we = 1'b0; bus.din = '0; bus.dp = '0; bus.blank = '0;
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({bus.frame, bus.n_an, bus.n_seg} !== 13'h0FFF)
            $display("FAIL reset_outputs got=%h want=%h", {bus.frame, bus.n_an, bus.n_seg}, 13'h0FFF);
        else passed++;
        @(negedge clk) rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++;
            if (c < 3 && bus.n_an !== 4'hF)
                $display("FAIL dead_after_reset cyc=%0d got=%h want=F", c, bus.n_an);
            else if (c == 3 && {bus.n_an, bus.n_seg} !== 12'hEC0)
                $display("FAIL first_anode got=%h want=EC0", {bus.n_an, bus.n_seg});
            else passed++;
        end
        cyc = 3;
        while (bus.frame !== 1'b1 && cyc < 100) begin step(); cyc++; end
        total++;
        if (cyc !== 40) $display("FAIL first_frame got=%0d want=40", cyc);
        else passed++;
        cyc = 0;
        do begin step(); cyc++; end while (bus.frame !== 1'b1 && cyc < 100);
        total++;
        if (cyc !== FRAME_LEN) $display("FAIL frame_period got=%0d want=%0d", cyc, FRAME_LEN);
        else passed++;
        $display("reset: first frame and period measured");
    endtask

    task automatic test_write();
        bit ok;
        logic [12:0] e;
        write(16'h1234, 4'b0001, 4'b0000);
        wait_frame(ok);
        total++;
        if (!ok) $display("FAIL write_frame_timeout got=none want=frame");
        else passed++;
        push_frame(16'h1234, 4'b0001, 4'b0000);
        for (int j = 0; j < FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL write j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
        end
        $display("write: frame of 1234 checked");
    endtask

    task automatic test_tearing();
        logic [12:0] e;
        push_frame(16'h1234, 4'b0001, 4'b0000);
        for (int j = 0; j < FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL tearing_old j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
            if (j == 14) begin
                bus.din = 16'h00FF; bus.dp = 4'b0000; bus.blank = 4'b0000; bus.we = 1'b1;
            end
            if (j == 15) bus.we = 1'b0;
        end
        push_frame(16'h00FF, 4'b0000, 4'b0000);
        for (int j = 0; j < FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL tearing_new j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
        end
        $display("tearing: mid-frame 00FF held until frame boundary");
    endtask

    task automatic test_collision();
        logic [12:0] e;
        push_frame(16'h00FF, 4'b0000, 4'b0000);
        for (int j = 0; j < FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL collision_pre j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
            if (j == 4) begin bus.din = 16'h5555; bus.we = 1'b1; end
            if (j == 5) bus.we = 1'b0;
            // Captured on the wrap edge itself.
            if (j == 38) begin bus.din = 16'hABCD; bus.we = 1'b1; end
            if (j == 39) bus.we = 1'b0;
        end
        push_frame(16'h5555, 4'b0000, 4'b0000);
        push_frame(16'hABCD, 4'b0000, 4'b0000);
        for (int j = 0; j < 2 * FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL collision j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
        end
        $display("collision: 5555 then ABCD checked");
    endtask

    task automatic test_blank();
        bit ok;
        bit seen_b = 1'b0;
        logic [12:0] e;
        write(16'h1234, 4'b0001, 4'b0100);
        wait_frame(ok);
        total++;
        if (!ok) $display("FAIL blank_frame_timeout got=none want=frame");
        else passed++;
        push_frame(16'h1234, 4'b0001, 4'b0100);
        for (int j = 0; j < FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            if (bus.n_an === 4'hB) seen_b = 1'b1;
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL blank j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
        end
        total++;
        if (seen_b) $display("FAIL blank_anode got=B_seen want=never_B");
        else passed++;
        $display("blank: digit 2 dark over a frame");
    endtask

    task automatic test_midreset();
        bit ok;
        logic [12:0] e;
        write(16'h0008, 4'b0000, 4'b0000);
        wait_frame(ok);
        push_frame(16'h0008, 4'b0000, 4'b0000);
        for (int j = 0; j < FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL load8 j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
        end
        repeat (5) step();
        total++;
        if ({bus.n_an, bus.n_seg} !== 12'hE80)
            $display("FAIL pre_reset got=%h want=E80", {bus.n_an, bus.n_seg});
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.frame, bus.n_an, bus.n_seg} !== 13'h0FFF)
            $display("FAIL async_reset got=%h want=%h", {bus.frame, bus.n_an, bus.n_seg}, 13'h0FFF);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) step();
        total++;
        if ({bus.n_an, bus.n_seg} !== 12'hEC0)
            $display("FAIL display_cleared got=%h want=EC0", {bus.n_an, bus.n_seg});
        else passed++;
        write(16'h0008, 4'b0000, 4'b0000);
        wait_frame(ok);
        total++;
        if (!ok) $display("FAIL reload_frame_timeout got=none want=frame");
        else passed++;
        push_frame(16'h0008, 4'b0000, 4'b0000);
        for (int j = 0; j < FRAME_LEN; j++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({bus.frame, bus.n_an, bus.n_seg} !== e)
                $display("FAIL reload8 j=%0d got=%h want=%h", j, {bus.frame, bus.n_an, bus.n_seg}, e);
            else passed++;
        end
        $display("midreset: dark on reset, cleared, 0008 reloaded");
    endtask

    initial begin
        test_reset();
        test_write();
        test_tearing();
        test_collision();
        test_blank();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
